// File: rtl/imem_prog_ctrl_if.sv
// Burst-load stream and core fetch port of the instruction-memory programmer.
interface imem_prog_ctrl_if #(parameter int XLEN = 32);
  logic            burst_valid;
  logic            burst_ready;
  logic            burst_last;
  logic [XLEN-1:0] burst_data;
  logic [31:0]     fetch_addr;
  logic [XLEN-1:0] fetch_instr;

  modport master (output burst_valid, burst_data, burst_last, fetch_addr,
                  input  burst_ready, fetch_instr);
  modport slave  (input  burst_valid, burst_data, burst_last, fetch_addr,
                  output burst_ready, fetch_instr);
endinterface

// File: rtl/imem_prog_ctrl.sv
// Instruction store with manual/burst programming, run/halt gating of the core,
// and a combinational fetch port that substitutes NOP on misaligned/out-of-range PCs.
module imem_prog_ctrl #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 64,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013),
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  input  logic            Up,
  input  logic            Down,
  input  logic            Imem_write_en,
  input  logic [XLEN-1:0] Imem_write_instr,
  imem_prog_ctrl_if.slave bus,
  output logic            run,
  output logic [AW-1:0]   ptr,
  output logic [1:0]      state,
  output logic            err
);
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, RUN = 2'd2} state_t;

  state_t          st;
  logic [XLEN-1:0] mem [DEPTH];
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   fidx;
  logic            fault;

  assign state           = st;
  assign run             = (st == RUN);
  assign bus.burst_ready = (st == BURST);

  // Any address bit at or above AW+2 set means the PC lies beyond the store.
  assign fidx            = bus.fetch_addr[AW+1:2];
  assign fault           = (bus.fetch_addr[1:0] != 2'b00) | (|bus.fetch_addr[31:AW+2]);
  assign bus.fetch_instr = fault ? NOP : mem[fidx];

  always_comb begin
    we    = 1'b0;
    wdata = Imem_write_instr;
    if (st == IDLE && !start && !bus.burst_valid && Imem_write_en) begin
      we = 1'b1;
    end else if (st == BURST && bus.burst_valid) begin
      we    = 1'b1;
      wdata = bus.burst_data;
    end
  end

  // Storage is deliberately outside the reset domain so programs survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= IDLE;
      ptr <= '0;
      err <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            st  <= RUN;
            err <= 1'b0;
          end else if (bus.burst_valid) begin
            st  <= BURST;
            ptr <= '0;
          end else if (Up && !Down) begin
            ptr <= ptr + AW'(1);
          end else if (Down && !Up) begin
            ptr <= ptr - AW'(1);
          end
        end
        BURST: begin
          if (bus.burst_valid) begin
            ptr <= ptr + AW'(1);
            if (bus.burst_last) begin
              st <= IDLE;
            end else if (ptr == AW'(DEPTH - 1)) begin
              st  <= IDLE;
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (halt) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
      if (st == RUN && fault) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_prog_ctrl.sv
// Directed bench for imem_prog_ctrl: pointer stepping, manual write, burst load,
// overflow, run-time fetch faults and asynchronous reset mid-burst.
module tb_imem_prog_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt, Up, Down, Imem_write_en;
  logic [31:0] Imem_write_instr;
  logic        run, err;
  logic [5:0]  ptr;
  logic [1:0]  state;
  int          checks = 0;
  int          errors = 0;

  imem_prog_ctrl_if #(.XLEN(32)) bus ();

  imem_prog_ctrl #(.XLEN(32), .DEPTH(64), .NOP(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .Up(Up), .Down(Down),
    .Imem_write_en(Imem_write_en), .Imem_write_instr(Imem_write_instr),
    .bus(bus), .run(run), .ptr(ptr), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; halt = 0; Up = 0; Down = 0; Imem_write_en = 0;
    Imem_write_instr = '0; bus.burst_valid = 0; bus.burst_data = '0;
    bus.burst_last = 0; bus.fetch_addr = '0;
    #3;
    checks++;
    if ({state, ptr, err, run, bus.burst_ready} !== {2'd0, 6'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: state=%0d ptr=%0d err=%b run=%b ready=%b expected all 0",
               state, ptr, err, run, bus.burst_ready);
    end
    #9 reset = 1'b1;
  endtask

  task automatic test_ptr_step();
    Down = 1; tick(); Down = 0;
    checks++;
    if (ptr !== 6'd63) begin errors++; $display("FAIL down_wrap: ptr=%0d expected 63", ptr); end
    Up = 1; tick(); tick(); Up = 0;
    checks++;
    if (ptr !== 6'd1) begin errors++; $display("FAIL up_wrap: ptr=%0d expected 1", ptr); end
    Up = 1; Down = 1; tick(); Up = 0; Down = 0;
    checks++;
    if (ptr !== 6'd1) begin errors++; $display("FAIL up_down_hold: ptr=%0d expected 1", ptr); end
  endtask

  task automatic test_manual_write();
    Up = 1; tick(); tick(); tick(); Up = 0;
    checks++;
    if (ptr !== 6'd4) begin errors++; $display("FAIL step_to_4: ptr=%0d expected 4", ptr); end
    Imem_write_en = 1; Imem_write_instr = 32'h00AE0E13; Up = 1;
    tick();
    Imem_write_en = 0; Up = 0;
    checks++;
    if (ptr !== 6'd5) begin errors++; $display("FAIL write_up_ptr: ptr=%0d expected 5", ptr); end
    bus.fetch_addr = 32'd16; #1;
    checks++;
    if (bus.fetch_instr !== 32'h00AE0E13) begin
      errors++; $display("FAIL manual_fetch: got %h expected 00ae0e13", bus.fetch_instr);
    end
  endtask

  task automatic test_burst();
    logic [31:0] words [3];
    words[0] = 32'h00500093; words[1] = 32'h00300113; words[2] = 32'h002081B3;
    bus.burst_valid = 1; bus.burst_data = words[0];
    tick();
    checks++;
    if ({state, ptr, bus.burst_ready} !== {2'd1, 6'd0, 1'b1}) begin
      errors++; $display("FAIL burst_entry: state=%0d ptr=%0d ready=%b expected 1/0/1",
                         state, ptr, bus.burst_ready);
    end
    tick();
    bus.burst_data = words[1]; tick();
    bus.burst_data = words[2]; bus.burst_last = 1; tick();
    bus.burst_valid = 0; bus.burst_last = 0;
    checks++;
    if ({state, ptr} !== {2'd0, 6'd3}) begin
      errors++; $display("FAIL burst_done: state=%0d ptr=%0d expected 0/3", state, ptr);
    end
    for (int i = 0; i < 3; i++) begin
      bus.fetch_addr = 32'(4 * i); #1;
      checks++;
      if (bus.fetch_instr !== words[i]) begin
        errors++; $display("FAIL burst_fetch%0d: got %h expected %h", i, bus.fetch_instr, words[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bus.burst_valid = 1; bus.burst_data = 32'hA000_0000;
    tick();
    for (int i = 0; i < 64; i++) begin
      bus.burst_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    bus.burst_data = 32'hA000_0040;
    checks++;
    if ({state, ptr, err, bus.burst_ready} !== {2'd0, 6'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL overflow: state=%0d ptr=%0d err=%b ready=%b expected 0/0/1/0",
                         state, ptr, err, bus.burst_ready);
    end
    bus.burst_valid = 0;
    bus.fetch_addr = 32'd0; #1;
    checks++;
    if (bus.fetch_instr !== 32'hA000_0000) begin
      errors++; $display("FAIL overflow_word0: got %h expected a0000000", bus.fetch_instr);
    end
    bus.fetch_addr = 32'd252; #1;
    checks++;
    if (bus.fetch_instr !== 32'hA000_003F) begin
      errors++; $display("FAIL overflow_word63: got %h expected a000003f", bus.fetch_instr);
    end
    bus.fetch_addr = 32'd0;
  endtask

  task automatic test_run_fault();
    start = 1; tick(); start = 0;
    checks++;
    if ({run, err, state} !== {1'b1, 1'b0, 2'd2}) begin
      errors++; $display("FAIL start_run: run=%b err=%b state=%0d expected 1/0/2", run, err, state);
    end
    bus.fetch_addr = 32'd6; #1;
    checks++;
    if (bus.fetch_instr !== 32'h0000_0013) begin
      errors++; $display("FAIL misalign_nop: got %h expected 00000013", bus.fetch_instr);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL misalign_err: err=%b expected 1", err); end
    bus.fetch_addr = 32'd0; halt = 1;
    checks++;
    if (run !== 1'b1) begin errors++; $display("FAIL run_before_halt: run=%b expected 1", run); end
    tick(); halt = 0;
    checks++;
    if ({run, state, err} !== {1'b0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL halt: run=%b state=%0d err=%b expected 0/0/1", run, state, err);
    end
    start = 1; tick(); start = 0;
    checks++;
    if ({run, err} !== 2'b10) begin
      errors++; $display("FAIL restart_clear: run=%b err=%b expected 1/0", run, err);
    end
    bus.fetch_addr = 32'd256; #1;
    checks++;
    if (bus.fetch_instr !== 32'h0000_0013) begin
      errors++; $display("FAIL range_nop: got %h expected 00000013", bus.fetch_instr);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL range_err: err=%b expected 1", err); end
    bus.fetch_addr = 32'd0; halt = 1; tick(); halt = 0;
  endtask

  task automatic test_reset_mid_burst();
    bus.burst_valid = 1; bus.burst_data = 32'hB000_0000;
    tick(); tick();
    bus.burst_data = 32'hB000_0001; tick();
    bus.burst_data = 32'hB000_0002;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state, ptr, bus.burst_ready, err, run} !== {2'd0, 6'd0, 3'b000}) begin
      errors++; $display("FAIL reset_mid_burst: state=%0d ptr=%0d ready=%b err=%b run=%b expected 0s",
                         state, ptr, bus.burst_ready, err, run);
    end
    bus.burst_valid = 0;
    #2 reset = 1'b1;
    bus.fetch_addr = 32'd0; #1;
    checks++;
    if (bus.fetch_instr !== 32'hB000_0000) begin
      errors++; $display("FAIL retain_w0: got %h expected b0000000", bus.fetch_instr);
    end
    bus.fetch_addr = 32'd4; #1;
    checks++;
    if (bus.fetch_instr !== 32'hB000_0001) begin
      errors++; $display("FAIL retain_w1: got %h expected b0000001", bus.fetch_instr);
    end
    bus.fetch_addr = 32'd8; #1;
    checks++;
    if (bus.fetch_instr !== 32'hA000_0002) begin
      errors++; $display("FAIL no_write_w2: got %h expected a0000002", bus.fetch_instr);
    end
    bus.fetch_addr = 32'd6; tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL idle_fault_no_err: err=%b expected 0", err); end
    bus.fetch_addr = 32'd0;
  endtask

  initial begin
    test_reset();
    test_ptr_step();
    test_manual_write();
    test_burst();
    test_overflow();
    test_run_fault();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
